// File: rtl/matmul_pkg.sv
// Shared types, parameter defaults and helpers for the matmul sequencer.
// sat_add() is only referenced when MATMUL_SCHED_SAT_EN is defined.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        FIN
    } sched_state_t;

    localparam int unsigned DEF_N      = 32;
    localparam int unsigned DEF_LEN    = 4;
    localparam int unsigned DEF_ROWS   = 4;
    localparam int unsigned DEF_COLS   = 4;
    localparam int unsigned DEF_INNER  = 8;
    localparam int unsigned DEF_DP_LAT = 0;

    // Index width for a count of n items; a single item still gets one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add of two w-bit values (w <= 63) held in the low bits, clamped to the w-bit range.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic signed [64:0] sa, sb, sum, max_v, min_v;
        sa    = ($signed({1'b0, a}) <<< (65 - w)) >>> (65 - w);
        sb    = ($signed({1'b0, b}) <<< (65 - w)) >>> (65 - w);
        sum   = sa + sb;
        max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
        min_v = -max_v - 65'sd1;
        if (sum > max_v) begin
            sum = max_v;
        end else if (sum < min_v) begin
            sum = min_v;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/matmul_acc.sv
// DotProd valid delay line and per-element accumulator.
// MATMUL_SCHED_SAT_EN selects sticky signed saturation instead of modulo-2^N wrap.
module matmul_acc
    import matmul_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         rd_en_i,
    input  logic [N-1:0] dp_result_i,
    output logic [N-1:0] acc_next_c_o,
    output logic         last_c_o
);

    localparam logic [DEPTH-1:0] LAST_ONLY = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [N-1:0]     acc_q, acc_d;
`ifdef MATMUL_SCHED_SAT_EN
    logic             sat_q, sat_d;
    logic [N-1:0]     sum_sat, sum_wrap;
`endif

    always_comb begin
        vld_d = (vld_q << 1) | DEPTH'(rd_en_i);
        acc_d = acc_q;
`ifdef MATMUL_SCHED_SAT_EN
        sat_d    = sat_q;
        sum_wrap = acc_q + dp_result_i;
        sum_sat  = N'(sat_add(64'(acc_q), 64'(dp_result_i), N));
`endif
        if (clear_i) begin
            acc_d = '0;
`ifdef MATMUL_SCHED_SAT_EN
            sat_d = 1'b0;
`endif
        end else if (vld_q[DEPTH-1]) begin
`ifdef MATMUL_SCHED_SAT_EN
            // Once clamped, the element stays pinned until the next clear.
            if (!sat_q) begin
                acc_d = sum_sat;
                sat_d = (sum_sat != sum_wrap);
            end
`else
            acc_d = acc_q + dp_result_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            acc_q <= '0;
`ifdef MATMUL_SCHED_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
`ifdef MATMUL_SCHED_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign acc_next_c_o = acc_d;
    // Final chunk result is at the output with nothing else in flight.
    assign last_c_o     = (vld_q == LAST_ONLY);

endmodule

// File: rtl/matmul_sched.sv
// Sequencer for a LEN-wide DotProd computing C = A x B chunk by chunk, emitting C[i][j] via valid/ready.
// Define MATMUL_SCHED_SAT_EN for signed saturating accumulation (default: modulo-2^N wrap).
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned LEN    = DEF_LEN,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned INNER  = DEF_INNER,
    parameter int unsigned DP_LAT = DEF_DP_LAT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                rd_en,
    output logic [idx_w(ROWS)-1:0]              rd_row,
    output logic [idx_w(COLS)-1:0]              rd_col,
    output logic [idx_w(INNER / LEN)-1:0]       rd_chunk,
    input  logic [N-1:0]                        dp_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N-1:0]                        out_data,
    output logic [idx_w(ROWS)-1:0]              out_row,
    output logic [idx_w(COLS)-1:0]              out_col
);

    localparam int unsigned CHUNKS  = INNER / LEN;
    localparam int unsigned ROW_W   = idx_w(ROWS);
    localparam int unsigned COL_W   = idx_w(COLS);
    localparam int unsigned CHUNK_W = idx_w(CHUNKS);

    sched_state_t       state_q;
    logic               busy_q, done_q, rd_en_q, out_valid_q;
    logic [ROW_W-1:0]   rd_row_q, out_row_q;
    logic [COL_W-1:0]   rd_col_q, out_col_q;
    logic [CHUNK_W-1:0] rd_chunk_q;
    logic [N-1:0]       out_data_q, acc_next_c;
    logic               last_c, clear_c, last_elem_c, last_col_c;

    assign last_col_c  = (rd_col_q == COL_W'(COLS - 1));
    assign last_elem_c = last_col_c && (rd_row_q == ROW_W'(ROWS - 1));
    assign clear_c     = ((state_q == IDLE) && start) || ((state_q == EMIT) && out_ready);

    matmul_acc #(
        .N     (N),
        .DEPTH (1 + DP_LAT)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_c),
        .rd_en_i      (rd_en_q),
        .dp_result_i  (dp_result),
        .acc_next_c_o (acc_next_c),
        .last_c_o     (last_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            rd_chunk_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_row_q   <= '0;
                        rd_col_q   <= '0;
                        rd_chunk_q <= '0;
                    end
                end
                ISSUE: begin
                    if (rd_chunk_q == CHUNK_W'(CHUNKS - 1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_chunk_q <= rd_chunk_q + CHUNK_W'(1);
                    end
                end
                DRAIN: begin
                    // Capture the sum including the result arriving this cycle.
                    if (last_c) begin
                        state_q     <= EMIT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_next_c;
                        out_row_q   <= rd_row_q;
                        out_col_q   <= rd_col_q;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_elem_c) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= ISSUE;
                            rd_en_q    <= 1'b1;
                            rd_chunk_q <= '0;
                            rd_col_q   <= last_col_c ? '0 : rd_col_q + COL_W'(1);
                            if (last_col_c) begin
                                rd_row_q <= rd_row_q + ROW_W'(1);
                            end
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_row    = rd_row_q;
    assign rd_col    = rd_col_q;
    assign rd_chunk  = rd_chunk_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule
